// File: rtl/sram1rw_req_ctrl.sv
// Request-side controller for a single-port 1RW SRAM macro: valid/ready request and
// response channels, with partial-mask writes executed as read-modify-write.
//
// state   | meaning
// IDLE    | accepting requests; full/zero-mask writes complete here
// RD_WAIT | macro output enabled, read data captured into resp_data
// RESP    | response held until the consumer accepts it
// RMW_RD  | macro output enabled, old word merged with latched write lanes
// RMW_WR  | merged word written back to the latched address
module sram1rw_req_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_mask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RESP,
        RMW_RD,
        RMW_WR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rmw_addr;
    logic [DATA_W-1:0] rmw_wdata;
    logic [MASK_W-1:0] rmw_mask;
    logic [DATA_W-1:0] merge_buf;
    logic              accept;
    logic              mask_full;
    logic              mask_none;

    // Reset is folded in so the macro pins go idle asynchronously, not at the next edge.
    assign req_ready  = (state == IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign mask_full  = &req_mask;
    assign mask_none  = (req_mask == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rmw_addr  <= '0;
            rmw_wdata <= '0;
            rmw_mask  <= '0;
            merge_buf <= '0;
            resp_data <= '0;
        end else begin
            if (accept && req_write && !mask_full && !mask_none) begin
                rmw_addr  <= req_addr;
                rmw_wdata <= req_wdata;
                rmw_mask  <= req_mask;
            end
            if (state == RD_WAIT) begin
                resp_data <= sram_o;
            end
            if (state == RMW_RD) begin
                for (int k = 0; k < MASK_W; k++) begin
                    merge_buf[8*k +: 8] <= rmw_mask[k] ? rmw_wdata[8*k +: 8] : sram_o[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_oeb  = 1'b1;
        sram_a    = '0;
        sram_i    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_write) begin
                        sram_csb  = 1'b0;
                        sram_a    = req_addr;
                        state_nxt = RD_WAIT;
                    end else if (mask_full) begin
                        sram_csb = 1'b0;
                        sram_web = 1'b0;
                        sram_a   = req_addr;
                        sram_i   = req_wdata;
                    end else if (!mask_none) begin
                        sram_csb  = 1'b0;
                        sram_a    = req_addr;
                        state_nxt = RMW_RD;
                    end
                end
            end
            RD_WAIT: begin
                sram_oeb  = 1'b0;
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            RMW_RD: begin
                sram_oeb  = 1'b0;
                state_nxt = RMW_WR;
            end
            RMW_WR: begin
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_a    = rmw_addr;
                sram_i    = merge_buf;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram1rw_req_ctrl.sv
// Directed bench for sram1rw_req_ctrl with a behavioural 256x128 macro model that
// drives X on sram_o whenever the output enable is inactive.
module tb_sram1rw_req_ctrl;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [7:0]   req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_mask;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_data;
    logic         sram_csb;
    logic         sram_web;
    logic         sram_oeb;
    logic [7:0]   sram_a;
    logic [127:0] sram_i;
    logic [127:0] sram_o;

    logic [127:0] mem [256];
    logic [127:0] rd_q;

    int n_checks = 0;
    int n_fail   = 0;
    int n_csb_low = 0;
    int n_web_low = 0;
    int n_oeb_low = 0;

    localparam logic [127:0] D_FULL = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D_AA   = {16{8'hAA}};
    localparam logic [127:0] D_55   = {16{8'h55}};
    localparam logic [127:0] D_RMW  = 128'hAAAAAAAAAAAAAAAA55555555AAAAAAAA;
    localparam logic [127:0] D_OLD  = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;

    always #5 clock = ~clock;

    sram1rw_req_ctrl #(.ADDR_W(8), .DATA_W(128)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_oeb   (sram_oeb),
        .sram_a     (sram_a),
        .sram_i     (sram_i),
        .sram_o     (sram_o)
    );

    always @(posedge clock) begin
        if (sram_csb === 1'b0) begin
            if (sram_web === 1'b0) mem[sram_a] <= sram_i;
            else                   rd_q <= mem[sram_a];
        end
        if (sram_csb === 1'b0) n_csb_low++;
        if (sram_web === 1'b0) n_web_low++;
        if (sram_oeb === 1'b0) n_oeb_low++;
    end

    assign sram_o = (sram_oeb === 1'b0) ? rd_q : 'x;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [127:0] data, input logic [15:0] mask);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data; req_mask = mask;
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [127:0] exp);
        int base;
        base = n_csb_low;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        #1;
        chk({tag, "_acc_csb"}, sram_csb, 1'b0);
        tick();
        req_valid = 1'b0; req_addr = '0;
        #1;
        chk({tag, "_rdwait_oeb"}, sram_oeb, 1'b0);
        chk({tag, "_rdwait_valid"}, resp_valid, 1'b0);
        tick();
        chk({tag, "_resp_valid"}, resp_valid, 1'b1);
        chk({tag, "_resp_data"}, resp_data, exp);
        tick();
        chk({tag, "_idle_valid"}, resp_valid, 1'b0);
        chk({tag, "_idle_ready"}, req_ready, 1'b1);
        chk({tag, "_csb_cycles"}, n_csb_low - base, 1);
    endtask

    initial begin
        int base_csb;
        int base_web;
        int base_oeb;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_mask = '0; resp_ready = 1'b1;
        #2;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_pins", {sram_csb, sram_web, sram_oeb}, 3'b111);
        chk("rst_addr", sram_a, '0);
        chk("rst_wdata", sram_i, '0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rel_req_ready", req_ready, 1'b1);

        // full writes back to back at both address extremes
        base_csb = n_csb_low;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00; req_wdata = D_FULL; req_mask = 16'hFFFF;
        #1;
        chk("fw0_pins", {sram_csb, sram_web, sram_oeb}, 3'b001);
        chk("fw0_addr", sram_a, 8'h00);
        chk("fw0_data", sram_i, D_FULL);
        tick();
        req_addr = 8'hFF;
        #1;
        chk("fw1_ready", req_ready, 1'b1);
        chk("fw1_pins", {sram_csb, sram_web}, 2'b00);
        chk("fw1_addr", sram_a, 8'hFF);
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
        #1;
        chk("fw_idle_pins", {sram_csb, sram_web, sram_a, sram_i}, {2'b11, 8'h00, 128'h0});
        chk("fw_csb_cycles", n_csb_low - base_csb, 2);
        rd_chk("rd_ff", 8'hFF, D_FULL);
        rd_chk("rd_00", 8'h00, D_FULL);

        // read-modify-write on lanes 4..7
        wr(8'h10, D_AA, 16'hFFFF);
        base_oeb = n_oeb_low;
        base_csb = n_csb_low;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = D_55; req_mask = 16'h00F0;
        #1;
        chk("rmw_acc_pins", {sram_csb, sram_web, sram_oeb}, 3'b011);
        chk("rmw_acc_addr", sram_a, 8'h10);
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
        #1;
        chk("rmw_rd_ready", req_ready, 1'b0);
        chk("rmw_rd_pins", {sram_csb, sram_web, sram_oeb}, 3'b110);
        tick();
        chk("rmw_wr_ready", req_ready, 1'b0);
        chk("rmw_wr_pins", {sram_csb, sram_web, sram_oeb}, 3'b001);
        chk("rmw_wr_addr", sram_a, 8'h10);
        chk("rmw_wr_data", sram_i, D_RMW);
        tick();
        chk("rmw_done_ready", req_ready, 1'b1);
        chk("rmw_oeb_cycles", n_oeb_low - base_oeb, 1);
        chk("rmw_csb_cycles", n_csb_low - base_csb, 2);
        rd_chk("rd_rmw", 8'h10, D_RMW);

        // zero-mask write is consumed without touching the macro
        base_csb = n_csb_low;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = '0; req_mask = 16'h0000;
        #1;
        chk("zm_acc_csb", sram_csb, 1'b1);
        chk("zm_acc_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        #1;
        chk("zm_next_ready", req_ready, 1'b1);
        chk("zm_csb_cycles", n_csb_low - base_csb, 0);
        rd_chk("rd_zm", 8'h10, D_RMW);

        // response backpressure for 10 cycles
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00;
        tick();
        req_valid = 1'b0; req_addr = '0;
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", resp_valid, 1'b1);
            chk("bp_data", resp_data, D_FULL);
            chk("bp_ready", req_ready, 1'b0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_valid", resp_valid, 1'b1);
        tick();
        chk("bp_idle_valid", resp_valid, 1'b0);
        chk("bp_idle_ready", req_ready, 1'b1);

        // asynchronous reset while a response is pending
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'hFF;
        tick();
        req_valid = 1'b0; req_addr = '0;
        tick();
        chk("ar_pre_valid", resp_valid, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_valid", resp_valid, 1'b0);
        chk("ar_data", resp_data, '0);
        chk("ar_ready", req_ready, 1'b0);
        tick();
        reset = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("ar_rel_ready", req_ready, 1'b1);

        // reset during RMW_RD suppresses the write-back
        wr(8'h20, D_OLD, 16'hFFFF);
        base_web = n_web_low;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = {16{8'hFF}}; req_mask = 16'h000F;
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
        #1;
        chk("rr_in_rmw_rd", sram_oeb, 1'b0);
        reset = 1'b1;
        #1;
        chk("rr_pins", {sram_csb, sram_web, sram_oeb}, 3'b111);
        chk("rr_ready", req_ready, 1'b0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rr_web_cycles", n_web_low - base_web, 0);
        rd_chk("rd_rr", 8'h20, D_OLD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
